// File: rtl/plic_mctx_pkg.sv
// Shared bus types, PLIC geometry and word-map offsets for the multi-context PLIC.
package plic_mctx_pkg;

  localparam int MEM_DATA_W = 32;
  localparam int MEM_MASK_W = MEM_DATA_W / 8;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_type_e;

  typedef struct packed {
    logic [31:0]           req_addr;
    logic [MEM_DATA_W-1:0] req_data;
    logic [MEM_MASK_W-1:0] req_mask;
    mem_type_e             req_type;
  } mem_req_t;

  typedef struct packed {
    logic [MEM_DATA_W-1:0] resp_data;
    logic                  resp_last;
  } mem_resp_t;

  localparam int PLIC_PRI_W_DEF = 3;
  localparam int PLIC_IRQ_N_DEF = 32;
  localparam int PLIC_CTX_N_DEF = 2;

  // Word offsets relative to the end of the priority block (idx N).
  localparam int PLIC_PEND_OFS   = 0;
  localparam int PLIC_MODE_OFS   = 1;
  localparam int PLIC_CTX_OFS    = 2;
  localparam int PLIC_CTX_STRIDE = 4;
  localparam int PLIC_CTX_IE     = 0;
  localparam int PLIC_CTX_THRES  = 1;
  localparam int PLIC_CTX_CLAIM  = 2;

  function automatic logic [MEM_DATA_W-1:0] mask_bytes(input logic [MEM_MASK_W-1:0] m);
    logic [MEM_DATA_W-1:0] r;
    for (int b = 0; b < MEM_MASK_W; b++) r[8*b +: 8] = {8{m[b]}};
    return r;
  endfunction

  function automatic logic [29:0] ctx_idx(input int irq_n, input int c, input int sel);
    return 30'(irq_n + PLIC_CTX_OFS + PLIC_CTX_STRIDE * c + sel);
  endfunction

endpackage

// File: rtl/plic_mctx_arb.sv
// Per-context winner select: highest priority above threshold among the masked
// sources, ties resolved toward the lowest id. Purely combinational.
module plic_mctx_arb
  import plic_mctx_pkg::*;
#(
  parameter int IRQ_N = 32,
  parameter int PRI_W = 3,
  parameter int ID_W  = 6
) (
  input  logic [IRQ_N-1:0]            i_mask,
  input  logic [IRQ_N-1:0][PRI_W-1:0] i_pri,
  input  logic [PRI_W-1:0]            i_thres,
  output logic [ID_W-1:0]             o_id,
  output logic                        o_valid
);

  logic [PRI_W-1:0] w_best;

  // Scanning downward with >= lets a lower id displace an equal-priority higher id.
  always_comb begin
    w_best  = '0;
    o_id    = '0;
    o_valid = 1'b0;
    for (int i = IRQ_N - 1; i >= 0; i--) begin
      if (i_mask[i] && (i_pri[i] > i_thres) && (i_pri[i] >= w_best)) begin
        w_best  = i_pri[i];
        o_id    = ID_W'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/plic_mctx.sv
// Multi-context PLIC on the mem_if slave bus: per-source priority/trigger mode and
// gateway, per-context enable/threshold/claim-complete, one registered ext_irq per context.
module plic_mctx
  import plic_mctx_pkg::*;
#(
  parameter int PLIC_PRI_W   = PLIC_PRI_W_DEF,
  parameter int PLIC_IRQ_N   = PLIC_IRQ_N_DEF,
  parameter int PLIC_CTX_N   = PLIC_CTX_N_DEF,
  parameter int PLIC_CLAIM_W = $clog2(PLIC_IRQ_N + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  mem_req_valid,
  output logic                  mem_req_ready,
  input  mem_req_t              mem_req,
  output logic                  mem_resp_valid,
  input  logic                  mem_resp_ready,
  output mem_resp_t             mem_resp,
  input  logic [PLIC_IRQ_N-1:0] ext_irq_src,
  output logic [PLIC_CTX_N-1:0] ext_irq
);

  localparam int N   = PLIC_IRQ_N;
  localparam int CTX = PLIC_CTX_N;
  localparam int PW  = PLIC_PRI_W;
  localparam int CW  = PLIC_CLAIM_W;

  logic [N-1:0]          r_s1, r_s2, r_s3;
  logic [N-1:0]          r_ip, r_gw_open, r_edge_seen, r_inflight, r_mode;
  logic [N-1:0][PW-1:0]  r_pri;
  logic [CTX-1:0][N-1:0] r_ie;
  logic [CTX-1:0][PW-1:0] r_thres;
  logic [CTX-1:0]        r_ext_irq;
  logic                  r_busy;
  logic [MEM_DATA_W-1:0] r_rdata;

  logic                  w_acc, w_rd, w_wr;
  logic [29:0]           w_idx;
  logic [MEM_DATA_W-1:0] w_bm, w_wdat, w_rdata;
  logic [N-1:0]          w_edge, w_set, w_claim_hit, w_cpl_hit;
  logic [CTX-1:0][CW-1:0] w_win_id;
  logic [CTX-1:0]        w_win_vld;
  logic                  w_unused;

  assign w_acc  = mem_req_valid & ~r_busy;
  assign w_rd   = w_acc & (mem_req.req_type == MEM_READ);
  assign w_wr   = w_acc & (mem_req.req_type == MEM_WRITE);
  assign w_idx  = mem_req.req_addr[31:2];
  assign w_bm   = mask_bytes(mem_req.req_mask);
  assign w_wdat = mem_req.req_data & w_bm;
  assign w_unused = &{1'b0, mem_req.req_addr[1:0], ext_irq_src[0]};

  assign mem_req_ready       = ~r_busy;
  assign mem_resp_valid      = r_busy;
  assign mem_resp.resp_data  = r_rdata;
  assign mem_resp.resp_last  = r_busy;
  assign ext_irq             = r_ext_irq;

  // Level sources follow the synchronised line; edge sources consume a fresh or queued edge.
  assign w_edge = r_s2 & ~r_s3;
  assign w_set  = r_gw_open & ((r_mode & (w_edge | r_edge_seen)) | (~r_mode & r_s2));

  for (genvar c = 0; c < CTX; c++) begin : g_arb
    plic_mctx_arb #(.IRQ_N(N), .PRI_W(PW), .ID_W(CW)) u_arb (
      .i_mask  (r_ip & r_ie[c]),
      .i_pri   (r_pri),
      .i_thres (r_thres[c]),
      .o_id    (w_win_id[c]),
      .o_valid (w_win_vld[c])
    );
  end

  always_comb begin
    w_rdata     = '0;
    w_claim_hit = '0;
    w_cpl_hit   = '0;
    for (int i = 1; i < N; i++) begin
      if (w_idx == 30'(i)) w_rdata[PW-1:0] = r_pri[i];
    end
    if (w_idx == 30'(N + PLIC_PEND_OFS)) w_rdata[N-1:0] = r_ip;
    if (w_idx == 30'(N + PLIC_MODE_OFS)) w_rdata[N-1:0] = r_mode;
    for (int c = 0; c < CTX; c++) begin
      if (w_idx == ctx_idx(N, c, PLIC_CTX_IE))    w_rdata[N-1:0]  = r_ie[c];
      if (w_idx == ctx_idx(N, c, PLIC_CTX_THRES)) w_rdata[PW-1:0] = r_thres[c];
      if (w_idx == ctx_idx(N, c, PLIC_CTX_CLAIM)) begin
        w_rdata[CW-1:0] = w_win_id[c];
        for (int i = 1; i < N; i++) begin
          if (w_rd && w_win_vld[c] && (w_win_id[c] == CW'(i))) w_claim_hit[i] = 1'b1;
          if (w_wr && (w_wdat == 32'(i)) && r_inflight[i] && r_ie[c][i]) w_cpl_hit[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1        <= '0;
      r_s2        <= '0;
      r_s3        <= '0;
      r_ip        <= '0;
      r_gw_open   <= '1;
      r_edge_seen <= '0;
      r_inflight  <= '0;
      r_mode      <= '0;
      r_pri       <= '0;
      r_ie        <= '0;
      r_thres     <= '0;
      r_ext_irq   <= '0;
    end else begin
      r_s1       <= {ext_irq_src[N-1:1], 1'b0};
      r_s2       <= r_s1;
      r_s3       <= r_s2;
      r_ip       <= (r_ip | w_set) & ~w_claim_hit;
      r_gw_open  <= (r_gw_open & ~w_claim_hit) | w_cpl_hit;
      r_inflight <= (r_inflight | w_claim_hit) & ~w_cpl_hit;
      // An edge landing while the gateway is (or is becoming) closed is remembered once.
      r_edge_seen <= r_mode & ((r_edge_seen & ~(w_set & ~w_claim_hit)) |
                               (w_edge & (~r_gw_open | w_claim_hit)));
      r_ext_irq  <= w_win_vld;
      if (w_wr) begin
        for (int i = 1; i < N; i++) begin
          if (w_idx == 30'(i)) r_pri[i] <= (r_pri[i] & ~w_bm[PW-1:0]) | w_wdat[PW-1:0];
        end
        if (w_idx == 30'(N + PLIC_MODE_OFS))
          r_mode <= ((r_mode & ~w_bm[N-1:0]) | w_wdat[N-1:0]) & ~N'(1);
        for (int c = 0; c < CTX; c++) begin
          if (w_idx == ctx_idx(N, c, PLIC_CTX_IE))
            r_ie[c] <= ((r_ie[c] & ~w_bm[N-1:0]) | w_wdat[N-1:0]) & ~N'(1);
          if (w_idx == ctx_idx(N, c, PLIC_CTX_THRES))
            r_thres[c] <= (r_thres[c] & ~w_bm[PW-1:0]) | w_wdat[PW-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_busy  <= 1'b0;
      r_rdata <= '0;
    end else if (w_acc) begin
      r_busy  <= 1'b1;
      r_rdata <= w_rd ? w_rdata : '0;
    end else if (r_busy && mem_resp_ready) begin
      r_busy  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_plic_mctx.sv
// Randomised + directed bench for plic_mctx: bus responses are checked by a scoreboard
// monitor against a transaction-level model of pending/gateway/claim state.
module tb_plic_mctx;
  import plic_mctx_pkg::*;

  localparam int N = 32;
  localparam int CTX = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic mem_req_valid = 1'b0;
  logic mem_req_ready;
  mem_req_t mem_req = '0;
  logic mem_resp_valid;
  logic mem_resp_ready = 1'b1;
  mem_resp_t mem_resp;
  logic [N-1:0] ext_irq_src = '0;
  logic [CTX-1:0] ext_irq;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  // reference state
  logic [2:0] m_pri [N];
  logic [N-1:0] m_ip, m_open, m_infl, m_pend, m_mode, m_src;
  logic [N-1:0] m_ie [CTX];
  int m_thres [CTX];

  always #5 clk = ~clk;

  plic_mctx dut (
    .clk(clk), .rstn(rstn),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req(mem_req),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp(mem_resp),
    .ext_irq_src(ext_irq_src), .ext_irq(ext_irq)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int idx_ctx(input int c, input int sel);
    return N + 2 + 4 * c + sel;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic int m_win(input int c);
    int best = 0;
    int bp = 0;
    for (int i = 1; i < N; i++)
      if (m_ip[i] && m_ie[c][i] && int'(m_pri[i]) > m_thres[c] && int'(m_pri[i]) > bp) begin
        bp = int'(m_pri[i]);
        best = i;
      end
    return best;
  endfunction

  function automatic logic [31:0] m_irq();
    logic [31:0] r = '0;
    for (int c = 0; c < CTX; c++) r[c] = (m_win(c) != 0);
    return r;
  endfunction

  function automatic void apply_gw(input int i);
    if (m_open[i]) begin
      if (!m_mode[i] && m_src[i]) m_ip[i] = 1'b1;
      if (m_mode[i] && m_pend[i]) begin
        m_ip[i] = 1'b1;
        m_pend[i] = 1'b0;
      end
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_pri[i] = '0;
    m_ip = '0; m_open = '1; m_infl = '0; m_pend = '0; m_mode = '0; m_src = '0;
    for (int c = 0; c < CTX; c++) begin
      m_ie[c] = '0;
      m_thres[c] = 0;
    end
  endfunction

  function automatic logic [31:0] model_read(input int idx);
    logic [31:0] r = '0;
    int id;
    if (idx > 0 && idx < N) r = 32'(m_pri[idx]);
    else if (idx == N) r = m_ip;
    else if (idx == N + 1) r = m_mode;
    for (int c = 0; c < CTX; c++) begin
      if (idx == idx_ctx(c, 0)) r = m_ie[c];
      if (idx == idx_ctx(c, 1)) r = 32'(m_thres[c]);
      if (idx == idx_ctx(c, 2)) begin
        id = m_win(c);
        r = 32'(id);
        if (id != 0) begin
          m_ip[id] = 1'b0;
          m_open[id] = 1'b0;
          m_infl[id] = 1'b1;
        end
      end
    end
    return r;
  endfunction

  function automatic void model_write(input int idx, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] t;
    if (idx > 0 && idx < N) begin
      t = merge(32'(m_pri[idx]), d, m);
      m_pri[idx] = t[2:0];
    end
    if (idx == N + 1) m_mode = merge(m_mode, d, m) & ~32'd1;
    for (int c = 0; c < CTX; c++) begin
      if (idx == idx_ctx(c, 0)) m_ie[c] = merge(m_ie[c], d, m) & ~32'd1;
      if (idx == idx_ctx(c, 1)) begin
        t = merge(32'(m_thres[c]), d, m);
        m_thres[c] = int'(t[2:0]);
      end
      if (idx == idx_ctx(c, 2)) begin
        t = merge('0, d, m);
        if (t > 0 && t < N && m_infl[t] && m_ie[c][t]) begin
          m_infl[t] = 1'b0;
          m_open[t] = 1'b1;
          apply_gw(int'(t));
        end
      end
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus(input bit wr, input int idx, input logic [31:0] d, input logic [3:0] m,
                     input logic [31:0] exp, input int stall);
    bit acc = 1'b0;
    exp_q.push_back(exp);
    mem_req.req_addr = 32'(idx) << 2;
    mem_req.req_data = d;
    mem_req.req_mask = m;
    mem_req.req_type = wr ? MEM_WRITE : MEM_READ;
    mem_req_valid = 1'b1;
    mem_resp_ready = (stall == 0);
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = mem_req_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check("req_accept_timeout", 32'(acc), 32'd1);
    mem_req_valid = 1'b0;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check("stall_resp_valid", 32'(mem_resp_valid), 32'd1);
      check("stall_req_ready", 32'(mem_req_ready), 32'd0);
      check("stall_resp_data", mem_resp.resp_data, exp);
      @(posedge clk);
      #1;
    end
    mem_resp_ready = 1'b1;
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      check("resp_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic reg_wr(input int idx, input logic [31:0] d, input logic [3:0] m);
    bus(1'b1, idx, d, m, 32'd0, 0);
    model_write(idx, d, m);
    tick(1);
  endtask

  task automatic reg_rd(input int idx, input int stall);
    logic [31:0] e;
    e = model_read(idx);
    bus(1'b0, idx, 32'd0, 4'hf, e, stall);
    tick(1);
  endtask

  task automatic check_irq(input string name);
    tick(2);
    @(negedge clk);
    check(name, 32'(ext_irq), m_irq());
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic v);
    ext_irq_src[i] = v;
    m_src[i] = v;
    tick(5);
    apply_gw(i);
  endtask

  task automatic pulse(input int i);
    ext_irq_src[i] = 1'b1;
    tick(3);
    ext_irq_src[i] = 1'b0;
    tick(4);
    if (m_mode[i]) begin
      if (m_open[i]) m_ip[i] = 1'b1;
      else m_pend[i] = 1'b1;
    end
  endtask

  task automatic do_reset();
    ext_irq_src = '0;
    rstn = 1'b0;
    tick(3);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    tick(1);
  endtask

  // scoreboard monitor: one expectation per completed response handshake
  always begin
    @(negedge clk);
    if (rstn && mem_resp_valid && mem_resp_ready) begin
      if (exp_q.size() == 0) check("unexpected_resp", 32'd1, 32'd0);
      else begin
        check("resp_data", mem_resp.resp_data, exp_q.pop_front());
        check("resp_last", 32'(mem_resp.resp_last), 32'd1);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int id, c, op;
    model_reset();
    do_reset();
    @(negedge clk);
    check("rst_ext_irq", 32'(ext_irq), 32'd0);
    check("rst_req_ready", 32'(mem_req_ready), 32'd1);
    check("rst_resp_valid", 32'(mem_resp_valid), 32'd0);
    @(posedge clk);
    #1;
    reg_rd(N, 0);

    // level source 3 through claim
    reg_wr(3, 32'd5, 4'hf);
    reg_wr(idx_ctx(0, 0), 32'h8, 4'hf);
    reg_wr(idx_ctx(0, 1), 32'd2, 4'hf);
    ext_irq_src[3] = 1'b1;
    m_src[3] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("lvl_irq_early", 32'(ext_irq), m_irq());
    apply_gw(3);
    @(negedge clk);
    check("lvl_irq_on", 32'(ext_irq), m_irq());
    @(posedge clk);
    #1;
    reg_rd(N, 0);
    reg_rd(idx_ctx(0, 2), 0);
    reg_rd(N, 0);
    check_irq("irq_after_claim");

    // complete with level still high, then a complete of a non-inflight id
    reg_wr(idx_ctx(0, 2), 32'd3, 4'hf);
    reg_rd(N, 0);
    check_irq("irq_after_complete");
    reg_wr(idx_ctx(0, 2), 32'd4, 4'hf);
    reg_rd(N, 0);
    reg_rd(idx_ctx(0, 2), 0);
    set_src(3, 1'b0);
    reg_wr(idx_ctx(0, 2), 32'd3, 4'hf);

    // edge source 5 with a queued second edge
    reg_wr(5, 32'd4, 4'hf);
    reg_wr(N + 1, 32'h20, 4'hf);
    reg_wr(idx_ctx(0, 0), 32'h28, 4'hf);
    pulse(5);
    reg_rd(idx_ctx(0, 2), 0);
    pulse(5);
    reg_rd(N, 0);
    reg_wr(idx_ctx(0, 2), 32'd5, 4'hf);
    reg_rd(N, 0);
    reg_rd(idx_ctx(0, 2), 0);
    reg_wr(idx_ctx(0, 2), 32'd5, 4'hf);
    reg_rd(N + 1, 0);

    // threshold gating and tie-break order
    reg_wr(2, 32'd3, 4'hf);
    reg_wr(6, 32'd3, 4'hf);
    reg_wr(7, 32'd1, 4'hf);
    reg_wr(idx_ctx(0, 0), 32'hC4, 4'hf);
    reg_wr(idx_ctx(0, 1), 32'd3, 4'hf);
    set_src(2, 1'b1);
    set_src(6, 1'b1);
    set_src(7, 1'b1);
    reg_rd(idx_ctx(0, 2), 0);
    check_irq("thres_blocks_irq");
    reg_wr(idx_ctx(0, 1), 32'd0, 4'hf);
    for (int k = 0; k < 3; k++) reg_rd(idx_ctx(0, 2), k);
    set_src(2, 1'b0);
    set_src(6, 1'b0);
    set_src(7, 1'b0);
    reg_wr(idx_ctx(0, 2), 32'd2, 4'hf);
    reg_wr(idx_ctx(0, 2), 32'd6, 4'hf);
    reg_wr(idx_ctx(0, 2), 32'd7, 4'hf);

    // two contexts with disjoint enables
    reg_wr(idx_ctx(0, 0), 32'h8, 4'hf);
    reg_wr(idx_ctx(1, 0), 32'h10, 4'hf);
    reg_wr(4, 32'd2, 4'hf);
    set_src(3, 1'b1);
    set_src(4, 1'b1);
    check_irq("two_ctx_irq");
    reg_rd(idx_ctx(1, 2), 0);
    check_irq("ctx1_claim_irq");
    reg_rd(N, 5);

    // register map corners
    reg_wr(0, 32'd7, 4'hf);
    reg_rd(0, 0);
    reg_wr(3, 32'd6, 4'h0);
    reg_rd(3, 0);
    reg_wr(N, 32'hffff_ffff, 4'hf);
    reg_rd(N, 0);
    reg_wr(idx_ctx(1, 0), 32'hffff_ffff, 4'h2);
    reg_rd(idx_ctx(1, 0), 0);
    reg_rd(idx_ctx(0, 3), 0);
    reg_rd(idx_ctx(CTX, 0), 0);
    reg_rd(500, 0);

    // async reset while a response is outstanding
    mem_req.req_addr = 32'(N) << 2;
    mem_req.req_type = MEM_READ;
    mem_req_valid = 1'b1;
    mem_resp_ready = 1'b0;
    exp_q.push_back(m_ip);
    @(posedge clk);
    #1;
    mem_req_valid = 1'b0;
    #2;
    check("busy_before_reset", 32'(mem_resp_valid), 32'd1);
    rstn = 1'b0;
    #1;
    check("rst_mid_resp_valid", 32'(mem_resp_valid), 32'd0);
    check("rst_mid_req_ready", 32'(mem_req_ready), 32'd1);
    check("rst_mid_ext_irq", 32'(ext_irq), 32'd0);
    exp_q.delete();
    mem_resp_ready = 1'b1;
    do_reset();

    // randomised traffic
    for (int i = 1; i < N; i++) reg_wr(i, 32'($urandom_range(0, 7)), 4'hf);
    reg_wr(N + 1, $urandom, 4'hf);
    for (int k = 0; k < CTX; k++) begin
      reg_wr(idx_ctx(k, 0), $urandom, 4'hf);
      reg_wr(idx_ctx(k, 1), 32'($urandom_range(0, 3)), 4'hf);
    end
    for (int s = 0; s < 120; s++) begin
      op = $urandom_range(0, 6);
      c = $urandom_range(0, CTX - 1);
      case (op)
        0, 1: begin
          id = $urandom_range(1, N - 1);
          if (m_mode[id]) pulse(id);
          else set_src(id, ~m_src[id]);
        end
        2: reg_rd(idx_ctx(c, 2), $urandom_range(0, 2));
        3: begin
          id = $urandom_range(0, N + 2);
          if (m_infl != 0 && $urandom_range(0, 2) != 0)
            for (int k = 0; k < N; k++) if (m_infl[(id + k) % N]) id = (id + k) % N;
          reg_wr(idx_ctx(c, 2), 32'(id), 4'hf);
        end
        4: check_irq("rand_irq");
        5: reg_rd($urandom_range(0, N + 11), 0);
        default: begin
          if ($urandom_range(0, 1) != 0) reg_wr($urandom_range(1, N - 1), $urandom, 4'($urandom));
          else reg_wr(idx_ctx(c, $urandom_range(0, 1)), $urandom, 4'($urandom));
        end
      endcase
    end
    reg_rd(N, 0);
    check_irq("final_irq");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
